// File: rtl/ahb_reg_bridge.sv
// AHB-Lite slave front-end for the UART register file: turns pipelined AHB
// transfers into single-cycle register strobes, with wait states and ERROR replies.
module ahb_reg_bridge #(
  parameter int          ADDR_WIDTH     = 32,
  parameter int          DATA_WIDTH     = 32,
  parameter int          REG_ADDR_WIDTH = 8,
  parameter int unsigned REG_SPACE      = 'h20
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      HSEL,
  input  logic [ADDR_WIDTH-1:0]     HADDR,
  input  logic [1:0]                HTRANS,
  input  logic                      HWRITE,
  input  logic [2:0]                HSIZE,
  input  logic [2:0]                HBURST,
  input  logic [3:0]                HPROT,
  input  logic                      HMASTLOCK,
  input  logic [DATA_WIDTH-1:0]     HWDATA,
  input  logic                      HREADY,
  output logic                      HREADYOUT,
  output logic                      HRESP,
  output logic [DATA_WIDTH-1:0]     HRDATA,
  output logic                      reg_wr_en,
  output logic                      reg_rd_en,
  output logic [REG_ADDR_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0]     reg_wdata,
  input  logic [DATA_WIDTH-1:0]     reg_rdata
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_RDATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  localparam logic [REG_ADDR_WIDTH:0] REG_SPACE_W = (REG_ADDR_WIDTH+1)'(REG_SPACE);

  state_t                    state_q, state_d;
  logic [REG_ADDR_WIDTH-1:0] reg_addr_q, reg_addr_d;

  logic                      accept;
  logic                      xfer_err;
  logic [REG_ADDR_WIDTH-1:0] offset;

  // Burst type, protection, lock and upper address bits carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{HTRANS[0], HBURST, HPROT, HMASTLOCK,
                           HADDR[ADDR_WIDTH-1:REG_ADDR_WIDTH]};

  assign offset   = HADDR[REG_ADDR_WIDTH-1:0];
  assign accept   = HSEL & HREADY & HTRANS[1];
  assign xfer_err = (HSIZE != 3'b010) || (offset[1:0] != 2'b00) ||
                    ({1'b0, offset} >= REG_SPACE_W);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= ST_IDLE;
      reg_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      reg_addr_q <= reg_addr_d;
    end
  end

  // Wait-state phases advance unconditionally; every other phase is a point
  // where the next address phase may be accepted.
  always_comb begin
    state_d    = state_q;
    reg_addr_d = reg_addr_q;
    case (state_q)
      ST_READ: state_d = ST_RDATA;
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        if (accept) begin
          if (xfer_err) begin
            state_d = ST_ERR1;
          end else begin
            state_d    = HWRITE ? ST_WRITE : ST_READ;
            reg_addr_d = offset;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    HRDATA    = '0;
    reg_wr_en = 1'b0;
    reg_rd_en = 1'b0;
    reg_wdata = '0;
    case (state_q)
      ST_WRITE: begin
        reg_wr_en = 1'b1;
        reg_wdata = HWDATA;
      end
      ST_READ: begin
        reg_rd_en = 1'b1;
        HREADYOUT = 1'b0;
      end
      ST_RDATA: HRDATA = reg_rdata;
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      ST_ERR2: HRESP = 1'b1;
      default: ;
    endcase
  end

  assign reg_addr = reg_addr_q;

endmodule

// File: tb/tb_ahb_reg_bridge.sv
// Bench for ahb_reg_bridge: directed scenarios plus random pipelined traffic,
// compared against a word-array model of the register space.
module tb_ahb_reg_bridge;

  logic        HCLK;
  logic        HRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic        reg_wr_en;
  logic        reg_rd_en;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [31:0] wdata;
  } xfer_t;

  xfer_t       seq[$];
  logic [31:0] model_mem [8];
  logic [31:0] regs [8];
  logic [31:0] env_rdata;

  ahb_reg_bridge dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HBURST    (HBURST),
    .HPROT     (HPROT),
    .HMASTLOCK (HMASTLOCK),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP),
    .HRDATA    (HRDATA),
    .reg_wr_en (reg_wr_en),
    .reg_rd_en (reg_rd_en),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  assign HREADY    = HREADYOUT;
  assign reg_rdata = env_rdata;

  // Register file seen by the bridge; read data appears the cycle after the strobe.
  always @(posedge HCLK) begin
    if (!HRESETn) begin
      for (int i = 0; i < 8; i++) regs[i] <= 32'h0;
    end else begin
      if (reg_wr_en) regs[reg_addr[4:2]] <= reg_wdata;
      if (reg_rd_en) env_rdata <= regs[reg_addr[4:2]];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic xfer_t mk(input logic sel, input logic [1:0] trans, input logic wr,
                               input logic [31:0] addr, input logic [2:0] size,
                               input logic [2:0] burst, input logic [31:0] wdata);
    xfer_t x;
    x.sel = sel; x.trans = trans; x.wr = wr; x.addr = addr;
    x.size = size; x.burst = burst; x.wdata = wdata;
    return x;
  endfunction

  function automatic logic is_err(input xfer_t x);
    return (x.size != 3'b010) || (x.addr[1:0] != 2'b00) || (x.addr[7:0] >= 8'h20);
  endfunction

  task automatic drive_idle();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = 32'h0;
    HSIZE = 3'b010; HBURST = 3'b000; HPROT = 4'h3; HMASTLOCK = 1'b0;
  endtask

  task automatic drive_addr(input xfer_t x);
    HSEL = x.sel; HTRANS = x.trans; HWRITE = x.wr; HADDR = x.addr;
    HSIZE = x.size; HBURST = x.burst;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) model_mem[i] = 32'h0;
  endtask

  // Plays the queue as back-to-back pipelined AHB traffic and checks each data phase.
  task automatic run_seq(input string name);
    xfer_t dp;
    bit    have_dp = 0;
    int    n;
    int    k = 0;
    while (seq.size() > 0 || have_dp) begin
      if (seq.size() > 0) drive_addr(seq[0]);
      else drive_idle();
      HWDATA = have_dp ? dp.wdata : $urandom;
      n = (have_dp && (is_err(dp) || !dp.wr)) ? 2 : 1;
      for (int c = 0; c < n; c++) begin
        @(negedge HCLK);
        if (!have_dp) begin
          chk($sformatf("%s[%0d] idle rdy/resp/wr/rd", name, k),
              {HREADYOUT, HRESP, reg_wr_en, reg_rd_en}, 4'b1000);
          chk($sformatf("%s[%0d] idle hrdata", name, k), HRDATA, 32'h0);
        end else if (is_err(dp)) begin
          chk($sformatf("%s[%0d] err%0d rdy/resp/wr/rd", name, k, c + 1),
              {HREADYOUT, HRESP, reg_wr_en, reg_rd_en}, (c == 0) ? 4'b0100 : 4'b1100);
        end else if (dp.wr) begin
          chk($sformatf("%s[%0d] wr rdy/resp/wr/rd", name, k),
              {HREADYOUT, HRESP, reg_wr_en, reg_rd_en}, 4'b1010);
          chk($sformatf("%s[%0d] wr reg_addr", name, k), reg_addr, dp.addr[7:0]);
          chk($sformatf("%s[%0d] wr reg_wdata", name, k), reg_wdata, dp.wdata);
          model_mem[dp.addr[4:2]] = dp.wdata;
        end else if (c == 0) begin
          chk($sformatf("%s[%0d] rd wait rdy/resp/wr/rd", name, k),
              {HREADYOUT, HRESP, reg_wr_en, reg_rd_en}, 4'b0001);
          chk($sformatf("%s[%0d] rd reg_addr", name, k), reg_addr, dp.addr[7:0]);
        end else begin
          chk($sformatf("%s[%0d] rdata rdy/resp/wr/rd", name, k),
              {HREADYOUT, HRESP, reg_wr_en, reg_rd_en}, 4'b1000);
          chk($sformatf("%s[%0d] rdata hrdata", name, k), HRDATA, model_mem[dp.addr[4:2]]);
        end
        @(posedge HCLK); #1;
      end
      have_dp = 0;
      if (seq.size() > 0) begin
        dp = seq.pop_front();
        have_dp = dp.sel && dp.trans[1];
      end
      k++;
    end
    drive_idle();
  endtask

  initial begin
    xfer_t       x;
    logic [31:0] a;
    HRESETn = 1'b0;
    HWDATA  = 32'h0;
    drive_idle();
    clear_model();
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    chk("reset rdy/resp/wr/rd", {HREADYOUT, HRESP, reg_wr_en, reg_rd_en}, 4'b1000);
    chk("reset hrdata", HRDATA, 32'h0);
    chk("reset reg_addr", {24'h0, reg_addr}, 32'h0);
    chk("reset reg_wdata", reg_wdata, 32'h0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;

    // Write then read; a reset lands during the read wait state.
    seq.push_back(mk(1, 2'b10, 1, 32'h08, 3'b010, 3'b000, 32'h0000_00C3));
    run_seq("preload");
    drive_addr(mk(1, 2'b10, 0, 32'h08, 3'b010, 3'b000, 32'h0));
    @(posedge HCLK); #1;
    drive_idle();
    chk("midread rd/rdy", {reg_rd_en, HREADYOUT}, 2'b10);
    HRESETn = 1'b0;
    #1;
    chk("reset-in-read rdy/resp/rd", {HREADYOUT, HRESP, reg_rd_en}, 3'b100);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    clear_model();
    seq.push_back(mk(1, 2'b10, 0, 32'h08, 3'b010, 3'b000, 32'h0));
    run_seq("after_reset");

    seq.push_back(mk(1, 2'b10, 1, 32'h04, 3'b010, 3'b000, 32'hA5A5_1234));
    run_seq("write04");

    seq.push_back(mk(1, 2'b10, 1, 32'h08, 3'b010, 3'b000, 32'h0000_00C3));
    seq.push_back(mk(0, 2'b00, 0, 32'h00, 3'b010, 3'b000, 32'h0));
    seq.push_back(mk(1, 2'b10, 0, 32'h08, 3'b010, 3'b000, 32'h0));
    run_seq("read08");

    seq.push_back(mk(1, 2'b10, 1, 32'h00, 3'b010, 3'b000, 32'h1234_5678));
    seq.push_back(mk(1, 2'b10, 0, 32'h00, 3'b010, 3'b000, 32'h0));
    run_seq("wr_then_rd");

    seq.push_back(mk(1, 2'b10, 1, 32'h01, 3'b000, 3'b000, 32'hDEAD_BEEF));
    seq.push_back(mk(1, 2'b10, 0, 32'h20, 3'b010, 3'b000, 32'h0));
    run_seq("errors");

    for (int i = 0; i < 4; i++)
      seq.push_back(mk(1, (i == 0) ? 2'b10 : 2'b11, 1, 32'(i * 4), 3'b010, 3'b011,
                       32'hB000_0000 + 32'(i)));
    run_seq("burst");

    for (int i = 0; i < 60; i++) begin
      a = $urandom;
      a[7:0] = 8'($urandom_range(0, 8'h27));
      if ($urandom_range(0, 3) != 0) a[7:0] = {3'b000, a[4:2], 2'b00};
      x = mk(($urandom_range(0, 5) != 0), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             a, ($urandom_range(0, 5) != 0) ? 3'b010 : 3'($urandom_range(0, 7)),
             3'($urandom_range(0, 7)), $urandom);
      seq.push_back(x);
    end
    run_seq("random");

    for (int i = 0; i < 8; i++)
      seq.push_back(mk(1, 2'b10, 0, 32'(i * 4), 3'b010, 3'b000, 32'h0));
    run_seq("readback");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
